// File: rtl/btn_pkg.sv
`default_nettype none
// ============================================================================
// Module : btn_pkg
// Brief  : Shared channel FSM encoding and default debounce length.
// Rev    : 1.0
// ============================================================================
package btn_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } btn_state_t;

    // 10 ms at 100 MHz; simulation overrides this with a small value.
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;

endpackage
`default_nettype wire

// File: rtl/btn_debounce_ch.sv
`default_nettype none
// ============================================================================
// Module : btn_debounce_ch
// Brief  : One button channel: 2-flop synchronizer, debounce FSM and counter,
//          registered level plus single-cycle press/release pulses.
// Rev    : 1.0
// ============================================================================
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    localparam int                 CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

    logic             r_s1;
    logic             r_s2;
    btn_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1        <= 1'b0;
            r_s2        <= 1'b0;
            r_state     <= STABLE_LO;
            r_cnt       <= '0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            r_s1        <= btn_raw;
            r_s2        <= r_s1;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;

            // The candidate level must be seen on DEBOUNCE_CYCLES consecutive
            // edges; the counter stops at CNT_LAST because commit leaves WAIT.
            case (r_state)
                STABLE_LO: begin
                    if (r_s2) begin
                        r_state <= WAIT_HI;
                        r_cnt   <= CNT_ONE;
                    end
                end
                WAIT_HI: begin
                    if (!r_s2) begin
                        r_state <= STABLE_LO;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state   <= STABLE_HI;
                        r_cnt     <= '0;
                        btn_level <= 1'b1;
                        btn_press <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                STABLE_HI: begin
                    if (!r_s2) begin
                        r_state <= WAIT_LO;
                        r_cnt   <= CNT_ONE;
                    end
                end
                WAIT_LO: begin
                    if (r_s2) begin
                        r_state <= STABLE_HI;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state     <= STABLE_LO;
                        r_cnt       <= '0;
                        btn_level   <= 1'b0;
                        btn_release <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_state <= STABLE_LO;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/btn_debouncer.sv
`default_nettype none
// ============================================================================
// Module : btn_debouncer
// Brief  : N_BTNS independent debounce channels for raw push-button pins.
// Rev    : 1.0
// ============================================================================
module btn_debouncer
    import btn_pkg::*;
#(
    parameter int N_BTNS          = 5,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_BTNS-1:0] btn_raw,
    output logic [N_BTNS-1:0] btn_level,
    output logic [N_BTNS-1:0] btn_press,
    output logic [N_BTNS-1:0] btn_release
);

    for (genvar i = 0; i < N_BTNS; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .btn_raw     (btn_raw[i]),
            .btn_level   (btn_level[i]),
            .btn_press   (btn_press[i]),
            .btn_release (btn_release[i])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_btn_debouncer.sv
`default_nettype none
// ============================================================================
// Module : tb_btn_debouncer
// Brief  : Directed stimulus with a queued scoreboard of expected pulses.
// Rev    : 1.0
// ============================================================================
module tb_btn_debouncer;

    localparam int N   = 2;
    localparam int D   = 4;
    localparam int LAT = D + 2;  // drive-after-edge E -> outputs change at edge E+LAT

    typedef struct {
        int cyc;
        int ch;
        bit is_press;
    } ev_t;

    logic         clk;
    logic         reset;
    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;

    int  checks   = 0;
    int  failures = 0;
    int  edge_n   = 0;
    bit  rst_q    = 1'b1;
    ev_t exp_q[$];

    btn_debouncer #(
        .N_BTNS          (N),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        edge_n <= edge_n + 1;
        rst_q  <= reset;
    end

    // Monitor: expected pulses are popped when their edge arrives.
    logic [N-1:0] exp_level = '0;
    always @(negedge clk) begin
        logic [N-1:0] exp_p;
        logic [N-1:0] exp_r;
        ev_t          ev;
        exp_p = '0;
        exp_r = '0;
        if (rst_q) begin
            exp_level = '0;
        end else begin
            while (exp_q.size() > 0 && exp_q[0].cyc <= edge_n) begin
                ev = exp_q.pop_front();
                if (ev.is_press) begin
                    exp_p[ev.ch]     = 1'b1;
                    exp_level[ev.ch] = 1'b1;
                end else begin
                    exp_r[ev.ch]     = 1'b1;
                    exp_level[ev.ch] = 1'b0;
                end
            end
        end
        checks++;
        if (btn_press !== exp_p) begin
            failures++;
            $display("FAIL press cyc=%0d got=%b exp=%b", edge_n, btn_press, exp_p);
        end
        checks++;
        if (btn_release !== exp_r) begin
            failures++;
            $display("FAIL release cyc=%0d got=%b exp=%b", edge_n, btn_release, exp_r);
        end
        checks++;
        if (btn_level !== exp_level) begin
            failures++;
            $display("FAIL level cyc=%0d got=%b exp=%b", edge_n, btn_level, exp_level);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input int cyc, input int ch, input bit is_press);
        ev_t e;
        e.cyc      = cyc;
        e.ch       = ch;
        e.is_press = is_press;
        exp_q.push_back(e);
    endtask

    initial begin
        int e0;
        reset   = 1'b1;
        btn_raw = 2'b11;

        // 1: reset held 3 edges with both pins high, presses 6 cycles after release
        step(3);
        reset = 1'b0;
        expect_ev(edge_n + LAT, 0, 1'b1);
        expect_ev(edge_n + LAT, 1, 1'b1);
        step(12);
        btn_raw = 2'b00;
        expect_ev(edge_n + LAT, 0, 1'b0);
        expect_ev(edge_n + LAT, 1, 1'b0);
        step(12);

        // 2: clean press on ch0, held for 50 cycles with no repeat
        btn_raw[0] = 1'b1;
        expect_ev(edge_n + 6, 0, 1'b1);
        step(50);

        // 5: release from STABLE_HI
        btn_raw[0] = 1'b0;
        expect_ev(edge_n + 6, 0, 1'b0);
        step(12);

        // 3: bounce high 3, low 1, then steady high
        e0 = edge_n;
        btn_raw[0] = 1'b1;
        step(3);
        btn_raw[0] = 1'b0;
        step(1);
        btn_raw[0] = 1'b1;
        expect_ev(e0 + 4 + 6, 0, 1'b1);
        step(20);
        btn_raw[0] = 1'b0;
        expect_ev(edge_n + 6, 0, 1'b0);
        step(12);

        // 4: 3-cycle glitch on ch1 produces nothing
        btn_raw[1] = 1'b1;
        step(3);
        btn_raw[1] = 1'b0;
        step(15);

        // 6: both rise, reset pulsed with cnt=2, count restarts afterwards
        btn_raw = 2'b11;
        step(4);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        expect_ev(edge_n + 6, 0, 1'b1);
        expect_ev(edge_n + 6, 1, 1'b1);
        step(15);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL pending_events got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
